// File: rtl/hls_pd_pkg.sv
// Shared types and helpers for the paired cnt_ls/pos stream FIFO.
package hls_pd_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int POS_W_DEF  = 16;
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 2;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] cnt_ls;
        logic [POS_W_DEF-1:0] pos;
    } pd_rec_t;

    // Pointers carry one extra wrap bit so that full and empty are distinguishable.
    function automatic int level_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/hls_fifo_rdport.sv
// One ap_fifo read channel: private read pointer, level, empty_n and
// first-word-fall-through output mux over the shared storage array.
module hls_fifo_rdport
    import hls_pd_pkg::*;
#(
    parameter int  ADDR_W = ADDR_W_DEF,
    parameter int  W      = CNT_W_DEF,
    localparam int LVL_W  = level_w(ADDR_W),
    localparam int DEPTH  = 1 << ADDR_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [LVL_W-1:0] wr_ptr,
    input  logic             rd,
    input  logic [W-1:0]     mem [DEPTH],
    output logic [W-1:0]     dout,
    output logic             empty_n,
    output logic [LVL_W-1:0] level
);

    logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        level    = wr_ptr - rd_ptr_q;
        empty_n  = (level != '0);
        dout     = mem[rd_ptr_q[ADDR_W-1:0]];
        rd_ptr_d = rd_ptr_q;
        if (rd && empty_n) begin
            rd_ptr_d = rd_ptr_q + LVL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/hls_pd_stream_fifo.sv
// Record FIFO written atomically from a valid/ready producer and drained as two
// independent ap_fifo channels; a slot frees only when both of its fields are read.
module hls_pd_stream_fifo
    import hls_pd_pkg::*;
#(
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  ADDR_W = ADDR_W_DEF,
    parameter int  CNT_W  = CNT_W_DEF,
    parameter int  POS_W  = POS_W_DEF,
    localparam int LVL_W  = level_w(ADDR_W)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_cnt_ls,
    input  logic [POS_W-1:0] in_pos,
    output logic [CNT_W-1:0] cnt_ls_dout,
    output logic             cnt_ls_empty_n,
    input  logic             cnt_ls_read,
    output logic [POS_W-1:0] pos_dout,
    output logic             pos_empty_n,
    input  logic             pos_read,
    output logic [LVL_W-1:0] cnt_level,
    output logic [LVL_W-1:0] pos_level
);

    logic [CNT_W-1:0] cnt_mem [DEPTH];
    logic [POS_W-1:0] pos_mem [DEPTH];

    logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             rst_done_q, rst_done_d;
    logic             wr_en;

    // in_ready is built from registered levels only, so a pop cannot write through in the same cycle.
    always_comb begin
        in_ready   = rst_done_q && (cnt_level != LVL_W'(DEPTH)) && (pos_level != LVL_W'(DEPTH));
        wr_en      = in_valid && in_ready;
        wr_ptr_d   = wr_en ? wr_ptr_q + LVL_W'(1) : wr_ptr_q;
        rst_done_d = 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q   <= '0;
            rst_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rst_done_q <= rst_done_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone decide what is valid.
    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            cnt_mem[wr_ptr_q[ADDR_W-1:0]] <= in_cnt_ls;
            pos_mem[wr_ptr_q[ADDR_W-1:0]] <= in_pos;
        end
    end

    hls_fifo_rdport #(.ADDR_W(ADDR_W), .W(CNT_W)) u_cnt_port (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .wr_ptr   (wr_ptr_q),
        .rd       (cnt_ls_read),
        .mem      (cnt_mem),
        .dout     (cnt_ls_dout),
        .empty_n  (cnt_ls_empty_n),
        .level    (cnt_level)
    );

    hls_fifo_rdport #(.ADDR_W(ADDR_W), .W(POS_W)) u_pos_port (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .wr_ptr   (wr_ptr_q),
        .rd       (pos_read),
        .mem      (pos_mem),
        .dout     (pos_dout),
        .empty_n  (pos_empty_n),
        .level    (pos_level)
    );

endmodule
